instr_sequencer: RTL and testbench

Upstream instruction feeder for the array-processor controller. The host pushes 32-bit instructions into a small FIFO. The block then issues them one at a time: it holds the controller in its active-low load/decode phase with the instruction stable, releases it, pulses `start`, waits for `finish_flag`, and retires the instruction. It sits between the host register interface and the controller's `instruction`/`reset`/`start`/`finish_flag` pins.

---
 rtl/instr_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: host-fed instruction FIFO that issues one instruction at a
// time to the array-processor controller (load/decode hold, start, wait, retire).
// Optional build macro SEQ_WATCHDOG_EN adds a WAIT-state timeout that parks the
// sequencer in ERR with a sticky error until clr_err.
//
// state  | meaning
// IDLE   | controller held in reset, waiting for go with a non-empty FIFO
// SETUP  | controller held in load/decode for SETUP_CYCLES with instruction stable
// START  | controller released, one-cycle start pulse
// WAIT   | controller running, waiting for finish_flag
// RETIRE | pop head, count it, chain to next instruction or report done
// ERR    | watchdog expired, controller held in reset until clr_err
module instr_sequencer #(
    parameter int DEPTH        = 8,
    parameter int SETUP_CYCLES = 162,
    parameter int TIMEOUT      = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [31:0]              wr_data,
    output logic                     wr_ready,
    input  logic                     go,
    input  logic                     clr_err,
    output logic [31:0]              ctrl_instr,
    output logic                     ctrl_rst_n,
    output logic                     ctrl_start,
    input  logic                     ctrl_finish,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [7:0]               retired_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(SETUP_CYCLES);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_RETIRE,
        S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [31:0]    instr_q, instr_d;
    logic [SW-1:0]  setup_cnt_q, setup_cnt_d;
    logic [7:0]     retired_q, retired_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           rst_n_q, rst_n_d;
    logic           start_q, start_d;
    logic           wr_ready_q, wr_ready_d;
    logic           push, pop;
    logic [31:0]    head_next;

`ifdef SEQ_WATCHDOG_EN
    logic [TW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           error_q, error_d;
`else
    logic           unused_clr_err;
    logic [TW-1:0]  unused_timeout;
    assign unused_clr_err = clr_err;
    assign unused_timeout = TW'(TIMEOUT - 1);
`endif

    // Next-state, FIFO bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        instr_d     = instr_q;
        setup_cnt_d = setup_cnt_q;
        retired_d   = retired_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        push        = wr_valid && wr_ready_q;
`ifdef SEQ_WATCHDOG_EN
        wait_cnt_d  = wait_cnt_q;
        error_d     = error_q;
`endif
        // When the last entry is popped while a new one is pushed, the new head
        // is the word being written this cycle, not yet in the array.
        if (level_q == LW'(1) && push) begin
            head_next = wr_data;
        end else begin
            head_next = mem_q[rd_ptr_q + AW'(1)];
        end

        case (state_q)
            S_IDLE: begin
                if (go && level_q != '0) begin
                    instr_d     = mem_q[rd_ptr_q];
                    setup_cnt_d = '0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                setup_cnt_d = setup_cnt_q + SW'(1);
                if (setup_cnt_q == SW'(SETUP_CYCLES - 1)) begin
                    state_d = S_START;
                end
            end
            S_START: begin
`ifdef SEQ_WATCHDOG_EN
                wait_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ctrl_finish) begin
                    state_d = S_RETIRE;
`ifdef SEQ_WATCHDOG_EN
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
`endif
                end
            end
            S_RETIRE: begin
                pop       = 1'b1;
                retired_d = retired_q + 8'd1;
                if (level_q > LW'(1) || push) begin
                    instr_d     = head_next;
                    setup_cnt_d = '0;
                    state_d     = S_SETUP;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef SEQ_WATCHDOG_EN
            S_ERR: begin
                if (clr_err) begin
                    error_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        busy_d     = (state_d != S_IDLE);
        rst_n_d    = (state_d == S_START) || (state_d == S_WAIT);
        start_d    = (state_d == S_START);
        wr_ready_d = (level_d != LW'(DEPTH));
    end

    // FIFO storage; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            instr_q     <= '0;
            setup_cnt_q <= '0;
            retired_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rst_n_q     <= 1'b0;
            start_q     <= 1'b0;
            wr_ready_q  <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
            wait_cnt_q  <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            instr_q     <= instr_d;
            setup_cnt_q <= setup_cnt_d;
            retired_q   <= retired_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            rst_n_q     <= rst_n_d;
            start_q     <= start_d;
            wr_ready_q  <= wr_ready_d;
`ifdef SEQ_WATCHDOG_EN
            wait_cnt_q  <= wait_cnt_d;
            error_q     <= error_d;
`endif
        end
    end

    assign wr_ready      = wr_ready_q;
    assign ctrl_instr    = instr_q;
    assign ctrl_rst_n    = rst_n_q;
    assign ctrl_start    = start_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign retired_count = retired_q;
    assign fifo_level    = level_q;
`ifdef SEQ_WATCHDOG_EN
    assign error         = error_q;
`else
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed/randomized bench with a queue-based model of the
// FIFO and the issue protocol of instr_sequencer.
module tb_instr_sequencer;

    localparam int DEPTH        = 8;
    localparam int SETUP_CYCLES = 162;
    localparam int TIMEOUT      = 16;
`ifdef SEQ_WATCHDOG_EN
    localparam int W_FIRST = 10;
`else
    localparam int W_FIRST = 65;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        go;
    logic        clr_err;
    logic [31:0] ctrl_instr;
    logic        ctrl_rst_n;
    logic        ctrl_start;
    logic        ctrl_finish;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  retired_count;
    logic [3:0]  fifo_level;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] q [$];
    int          retired_total = 0;

    instr_sequencer #(
        .DEPTH(DEPTH),
        .SETUP_CYCLES(SETUP_CYCLES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .go(go),
        .clr_err(clr_err),
        .ctrl_instr(ctrl_instr),
        .ctrl_rst_n(ctrl_rst_n),
        .ctrl_start(ctrl_start),
        .ctrl_finish(ctrl_finish),
        .busy(busy),
        .done(done),
        .error(error),
        .retired_count(retired_count),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        bit acc;
        acc = q.size() < DEPTH;
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        if (acc) q.push_back(d);
        check("push_level", 32'(fifo_level), 32'(q.size()));
        check("push_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
    endtask

    // Entered in the first SETUP cycle. mode 0: normal finish; 1: reset in WAIT;
    // 2: let the watchdog expire.
    task automatic run_one(input int w, input bit push_rt, input bit noise, input int mode);
        logic [31:0] exp_instr;
        logic [31:0] pd;
        int          n;
        int          bad;
        bit          acc;
        exp_instr = (q.size() > 0) ? q[0] : 32'hdead_beef;
        n   = 0;
        bad = 0;
        ctrl_finish = noise;
        while (ctrl_rst_n === 1'b0 && n < 1000) begin
            if (ctrl_instr !== exp_instr || ctrl_start !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
                bad++;
            tick();
            n++;
        end
        ctrl_finish = 1'b0;
        check("setup_len", n, SETUP_CYCLES);
        check("setup_stable", bad, 0);
        check("start_hi", 32'(ctrl_start), 1);
        tick();
        check("start_lo", 32'({ctrl_start, ctrl_rst_n}), 32'b01);
        if (mode == 1) begin
            repeat (w) tick();
            reset = 1'b0;
            tick();
            reset = 1'b1;
            q.delete();
            retired_total = 0;
            check("abort_rst_n", 32'(ctrl_rst_n), 0);
            check("abort_level", 32'(fifo_level), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_ready", 32'(wr_ready), 1);
            check("abort_retired", 32'(retired_count), 0);
            return;
        end
        if (mode == 2) begin
            repeat (TIMEOUT - 1) tick();
            check("wd_not_yet", 32'({error, busy}), 32'b01);
            tick();
            check("wd_error", 32'({error, busy, ctrl_rst_n}), 32'b110);
            check("wd_level", 32'(fifo_level), 32'(q.size()));
            ctrl_finish = 1'b1;
            tick();
            ctrl_finish = 1'b0;
            check("wd_no_retire", 32'(retired_count), 32'(retired_total % 256));
            clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
            check("wd_cleared", 32'({error, busy}), 32'b00);
            return;
        end
        repeat (w) tick();
        ctrl_finish = 1'b1;
        tick();
        ctrl_finish = 1'b0;
        acc = 1'b0;
        pd  = $urandom;
        if (push_rt) begin
            wr_valid = 1'b1;
            wr_data  = pd;
            acc      = q.size() < DEPTH;
        end
        tick();
        wr_valid = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(pd);
        retired_total++;
        check("retired", 32'(retired_count), 32'(retired_total % 256));
        check("ret_level", 32'(fifo_level), 32'(q.size()));
        check("ret_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
        if (q.size() > 0) begin
            check("chain", 32'({busy, done, ctrl_rst_n}), 32'b100);
        end else begin
            check("done_hi", 32'({busy, done}), 32'b01);
            tick();
            check("done_lo", 32'({busy, done}), 32'b00);
        end
    endtask

    initial begin
        int guard;
        reset       = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = '0;
        go          = 1'b0;
        clr_err     = 1'b0;
        ctrl_finish = 1'b0;
        repeat (3) tick();
        check("rst_instr", ctrl_instr, 0);
        check("rst_ctrl", 32'({ctrl_rst_n, ctrl_start}), 0);
        check("rst_flags", 32'({wr_ready, busy, done, error}), 32'b1000);
        check("rst_retired", 32'(retired_count), 0);
        check("rst_level", 32'(fifo_level), 0);
        reset = 1'b1;
        tick();

        // single instruction, go pulse
        push(32'h0022_1800);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("go_busy", 32'(busy), 1);
        run_one(W_FIRST, 1'b0, 1'b0, 0);

        // go with empty FIFO does nothing
        go = 1'b1;
        repeat (3) tick();
        go = 1'b0;
        check("go_empty", 32'({busy, done}), 0);

        // three instructions back to back with go held
        push(32'h0000_0000);
        push(32'h0400_0000);
        push(32'h1400_0000);
        go = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) run_one($urandom_range(0, 12), 1'b0, 1'b0, 0);
        go = 1'b0;

        // overfill, then push during RETIRE while full and while not full
        for (int i = 0; i < 9; i++) push($urandom);
        check("full_level", 32'(fifo_level), DEPTH);
        go = 1'b1;
        tick();
        go = 1'b0;
        run_one($urandom_range(0, 12), 1'b1, 1'b0, 0);
        run_one($urandom_range(0, 12), 1'b1, 1'b0, 0);
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            run_one($urandom_range(0, 12), 1'b0, 1'b1, 0);
            guard++;
        end

        // last entry popped with a simultaneous push chains into the new word
        push($urandom);
        go = 1'b1;
        tick();
        go = 1'b0;
        run_one(3, 1'b1, 1'b0, 0);
        run_one(3, 1'b0, 1'b0, 0);

        // finish_flag in IDLE is ignored
        ctrl_finish = 1'b1;
        repeat (5) tick();
        ctrl_finish = 1'b0;
        check("idle_finish", 32'(retired_count), 32'(retired_total % 256));
        check("idle_busy", 32'(busy), 0);

`ifdef SEQ_WATCHDOG_EN
        push($urandom);
        go = 1'b1;
        tick();
        go = 1'b0;
        run_one(0, 1'b0, 1'b0, 2);
        go = 1'b1;
        tick();
        go = 1'b0;
        run_one(4, 1'b0, 1'b0, 0);
`endif

        // reset while the controller is running
        push($urandom);
        push($urandom);
        go = 1'b1;
        tick();
        go = 1'b0;
        run_one(5, 1'b0, 1'b0, 1);
        tick();
        check("post_abort_idle", 32'({busy, ctrl_rst_n, done}), 0);

        // retired_count wraps after 256 retirements
        push($urandom);
        push($urandom);
        go = 1'b1;
        tick();
        guard = 0;
        while (retired_total < 256 && guard < 300) begin
            run_one($urandom_range(0, 3), 1'b1, 1'b0, 0);
            guard++;
        end
        check("wrap_total", retired_total, 256);
        check("wrap_count", 32'(retired_count), 0);
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            run_one($urandom_range(0, 3), 1'b0, 1'b0, 0);
            guard++;
        end
        go = 1'b0;
        check("end_level", 32'(fifo_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
